// File: rtl/reg_tx_packetizer_if.sv
// Register-update write bus: one {addr,data} word per valid&ready handshake.
interface w_busif;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (output addr, output data, output valid, input ready);
    modport slave  (input addr, input data, input valid, output ready);
endinterface

// File: rtl/reg_tx_packetizer.sv
// Buffers register-update words in a FIFO and serializes each one as a
// 7-byte frame: HEADER, addr, data[31:24..7:0], 8-bit additive checksum.
module reg_tx_packetizer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rstn,
    w_busif.slave                         bulk_rx,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_HEAD, S_ADDR, S_D3, S_D2, S_D1, S_D0, S_CSUM
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [7:0]              sum_q, sum_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;

    logic [WORD_W-1:0]       mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]       head_word;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    push;
    logic                    pop;

    // Space is judged from the registered count only, so a pop never
    // opens a slot within the same cycle.
    assign bulk_rx.ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push          = bulk_rx.valid && bulk_rx.ready;

    assign head_word = mem_q[rd_ptr_q];
    assign head_addr = head_word[WORD_W-1:DATA_WIDTH];
    assign head_data = head_word[DATA_WIDTH-1:0];

    // Next-state: pop into the frame register from IDLE, then walk the bytes.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sum_d      = sum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    addr_d     = head_addr;
                    data_d     = head_data;
                    sum_d      = head_addr + head_data[31:24] + head_data[23:16]
                               + head_data[15:8] + head_data[7:0];
                    state_d    = S_HEAD;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HEADER;
                end
            end
            default: begin
                if (tx_ready) begin
                    case (state_q)
                        S_HEAD: begin state_d = S_ADDR; tx_data_d = addr_q;         end
                        S_ADDR: begin state_d = S_D3;   tx_data_d = data_q[31:24];  end
                        S_D3:   begin state_d = S_D2;   tx_data_d = data_q[23:16];  end
                        S_D2:   begin state_d = S_D1;   tx_data_d = data_q[15:8];   end
                        S_D1:   begin state_d = S_D0;   tx_data_d = data_q[7:0];    end
                        S_D0:   begin state_d = S_CSUM; tx_data_d = sum_q;          end
                        default: begin
                            state_d    = S_IDLE;
                            tx_valid_d = 1'b0;
                        end
                    endcase
                end
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        busy_d  = (state_d != S_IDLE) || (count_d != '0);
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            sum_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sum_q      <= sum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_q[wr_ptr_q] <= {bulk_rx.addr, bulk_rx.data};
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_reg_tx_packetizer.sv
// Randomized bench for reg_tx_packetizer with a frame-level byte-stream model.
module tb_reg_tx_packetizer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [4:0]  fifo_count;

    w_busif bus ();

    reg_tx_packetizer #(.FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bulk_rx    (bus.slave),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         got_cyc [$];
    int         push_cyc [$];
    int         push_cnt = 0;
    int         stall_viol = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         rand_ready = 1'b0;

    // Reference: every accepted word becomes seven bytes on the stream.
    function automatic void model_push(input logic [7:0] a, input logic [31:0] d);
        int s;
        s = (a + d[31:24] + d[23:16] + d[15:8] + d[7:0]) % 256;
        exp_q.push_back(8'hA5);
        exp_q.push_back(a);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(8'(s));
    endfunction

    // One clock: observe handshakes at negedge, advance, settle inputs.
    task automatic step();
        @(negedge clk);
        if (rstn && bus.valid && bus.ready) begin
            model_push(bus.addr, bus.data);
            push_cnt++;
            push_cyc.push_back(cyc);
        end
        if (rstn && tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            got_cyc.push_back(cyc);
        end
        if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_viol++;
        prev_stall = rstn && tx_valid && !tx_ready;
        prev_data  = tx_data;
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 99) < 30);
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && !tx_valid && got_q.size() == exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic clear_hist();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        push_cyc.delete();
        push_cnt = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0b exp 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %0h exp 0", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", bus.ready); end
        rstn = 1'b1;
        step();
        clear_hist();
    endtask

    task automatic test_single_frame(input string name, input logic [7:0] a,
                                     input logic [31:0] d, input logic [7:0] sum);
        logic [7:0] want [7];
        bit ok;
        want[0] = 8'hA5; want[1] = a; want[2] = d[31:24]; want[3] = d[23:16];
        want[4] = d[15:8]; want[5] = d[7:0]; want[6] = sum;
        clear_hist();
        tx_ready = 1'b1;
        bus.addr = a; bus.data = d; bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        drain(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_timeout got 0 exp 1", name); end
        checks++;
        if (got_q.size() != 7) begin
            errors++; $display("FAIL %s_len got %0d exp 7", name, got_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (got_q[i] !== want[i]) begin
                    errors++; $display("FAIL %s_byte%0d got %0h exp %0h", name, i, got_q[i], want[i]);
                end
            end
            checks++;
            if (got_cyc[0] - push_cyc[0] != 2) begin
                errors++; $display("FAIL %s_latency got %0d exp 2", name, got_cyc[0] - push_cyc[0]);
            end
            checks++;
            if (got_cyc[6] - got_cyc[0] != 6) begin
                errors++; $display("FAIL %s_span got %0d exp 6", name, got_cyc[6] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_hist();
        tx_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.addr = 8'($urandom); bus.data = $urandom; bus.valid = 1'b1;
            step();
        end
        bus.valid = 1'b0;
        drain(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got 0 exp 1"); end
        checks++;
        if (got_q.size() != 14) begin
            errors++; $display("FAIL b2b_len got %0d exp 14", got_q.size());
        end else begin
            checks++;
            if (got_cyc[7] - push_cyc[0] != 10) begin
                errors++; $display("FAIL b2b_second_header got %0d exp 10", got_cyc[7] - push_cyc[0]);
            end
            for (int i = 0; i < 14; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL b2b_byte%0d got %0h exp %0h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random_stall();
        bit ok;
        int guard;
        clear_hist();
        stall_viol = 0;
        rand_ready = 1'b1;
        guard = 0;
        while (push_cnt < 100 && guard < 6000) begin
            bus.valid = ($urandom_range(0, 1) == 1);
            bus.addr  = 8'($urandom);
            bus.data  = $urandom;
            step();
            guard++;
        end
        bus.valid = 1'b0;
        checks++; if (push_cnt != 100) begin errors++; $display("FAIL rand_pushes got %0d exp 100", push_cnt); end
        drain(6000, ok);
        rand_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL rand_timeout got 0 exp 1"); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stall_stable got %0d exp 0", stall_viol); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_len got %0d exp %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand_byte%0d got %0h exp %0h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_fill_and_release();
        bit ok;
        int bad_ready;
        int bad_dec;
        int last_cnt;
        clear_hist();
        tx_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.valid = 1'b1; bus.addr = 8'($urandom); bus.data = $urandom;
            step();
        end
        bus.valid = 1'b0;
        checks++; if (push_cnt != 17) begin errors++; $display("FAIL fill_accepted got %0d exp 17", push_cnt); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b exp 0", bus.ready); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", fifo_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %0b exp 1", busy); end

        tx_ready  = 1'b1;
        bad_ready = 0;
        bad_dec   = 0;
        last_cnt  = 16;
        for (int i = 0; i < 400; i++) begin
            if (!busy && !tx_valid) break;
            step();
            if (bus.ready !== (fifo_count < 5'd16)) bad_ready++;
            if (last_cnt - int'(fifo_count) != 0 && last_cnt - int'(fifo_count) != 1) bad_dec++;
            last_cnt = int'(fifo_count);
        end
        drain(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL release_timeout got 0 exp 1"); end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL release_ready got %0d exp 0", bad_ready); end
        checks++; if (bad_dec != 0) begin errors++; $display("FAIL release_count_step got %0d exp 0", bad_dec); end
        checks++;
        if (got_q.size() != 17 * 7) begin
            errors++; $display("FAIL release_len got %0d exp %0d", got_q.size(), 17 * 7);
        end else begin
            for (int i = 0; i < 17 * 7; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL release_byte%0d got %0h exp %0h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [31:0] d1;
        clear_hist();
        tx_ready = 1'b1;
        d1 = $urandom;
        bus.addr = 8'($urandom); bus.data = d1; bus.valid = 1'b1;
        step();
        bus.addr = 8'($urandom); bus.data = $urandom;
        step();
        bus.valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (got_q.size() >= 3) break;
            step();
        end
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL midrst_reach got %0d exp 3", got_q.size()); end
        checks++; if (tx_data !== d1[23:16]) begin errors++; $display("FAIL midrst_d2 got %0h exp %0h", tx_data, d1[23:16]); end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid got %0b exp 0", tx_valid); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b exp 0", busy); end
        clear_hist();
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_resume got %0b exp 0", tx_valid); end
        bus.addr = 8'($urandom); bus.data = $urandom; bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        drain(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout got 0 exp 1"); end
        checks++;
        if (got_q.size() != 7) begin
            errors++; $display("FAIL midrst_len got %0d exp 7", got_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL midrst_byte%0d got %0h exp %0h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        rstn      = 1'b0;
        tx_ready  = 1'b0;
        bus.valid = 1'b0;
        bus.addr  = 8'h00;
        bus.data  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_frame("t1", 8'h12, 32'h11223344, 8'hBC);
        test_single_frame("t2", 8'hFF, 32'hFFFFFFFF, 8'hFB);
        test_back_to_back();
        test_random_stall();
        test_fill_and_release();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
